// File: rtl/uart_duplex_core.sv
// uart_duplex_core: single-clock full-duplex UART with an internal oversampling
// baud tick, configurable data width and stop-bit count, mid-bit sampling
// receiver with false-start rejection, framing and overrun reporting.
// Optional parity bit on TX and RX is enabled by defining UART_PARITY_EN.
module uart_duplex_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  Trans,
    input  logic                  RX,
    input  logic                  clearInterrupt,
    output logic                  TX,
    output logic                  TXBusy,
    output logic [DATA_WIDTH-1:0] ReceivedData,
    output logic                  RXInterrputFlag,
    output logic                  PARITYERRORFlag,
    output logic                  FRAMEERRORFlag,
    output logic                  OVERRUNFlag
);

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TTW     = $clog2(STOP_BITS * OVERSAMPLE);
    localparam int RTW     = $clog2(OVERSAMPLE);
    localparam int BCW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam bit ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Baud tick generator shared by TX and RX
    // ------------------------------------------------------------------
    logic [BW-1:0] r_baud_cnt;
    logic          w_tick;

    assign w_tick = (r_baud_cnt == BW'(DIV - 1));

    // Free-running divider; one-cycle tick at wrap (every cycle when DIV=1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                r_tx_state;
    logic                  r_tx;
    logic                  r_tx_busy;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par;
    logic [TTW-1:0]        r_tx_tcnt;
    logic [BCW-1:0]        r_tx_bcnt;

    // TX FSM: each bit lasts OVERSAMPLE ticks, the line value is registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (Trans) begin
                        r_tx_shift <= Data;
                        r_tx_par   <= (^Data) ^ ODD_BIT;
                        r_tx       <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_tcnt  <= '0;
                        r_tx_bcnt  <= '0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TTW'(OVERSAMPLE - 1)) begin
                            r_tx_tcnt  <= '0;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_state <= S_DATA;
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + TTW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TTW'(OVERSAMPLE - 1)) begin
                            r_tx_tcnt <= '0;
                            if (r_tx_bcnt == BCW'(DATA_WIDTH - 1)) begin
                                if (PAR_EN) begin
                                    r_tx       <= r_tx_par;
                                    r_tx_state <= S_PARITY;
                                end else begin
                                    r_tx       <= 1'b1;
                                    r_tx_state <= S_STOP;
                                end
                            end else begin
                                r_tx_bcnt  <= r_tx_bcnt + BCW'(1);
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                            end
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + TTW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TTW'(OVERSAMPLE - 1)) begin
                            r_tx_tcnt  <= '0;
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + TTW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == TTW'(STOP_BITS * OVERSAMPLE - 1)) begin
                            r_tx_tcnt  <= '0;
                            r_tx_busy  <= 1'b0;
                            r_tx_state <= S_IDLE;
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + TTW'(1);
                        end
                    end
                end
                default: begin
                    r_tx_state <= S_IDLE;
                    r_tx       <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TX     = r_tx;
    assign TXBusy = r_tx_busy;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic r_rx_sync1;
    logic r_rx_sync2;
    logic r_rx_prev;
    logic w_rx_fall;

    // Two-stage synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= RX;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync2;

    state_t                r_rx_state;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [RTW-1:0]        r_rx_tcnt;
    logic [BCW-1:0]        r_rx_bcnt;
    logic                  r_rx_perr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_int_flag;
    logic                  r_perr_flag;
    logic                  r_ferr_flag;
    logic                  r_ovr_flag;

    // RX FSM with mid-bit sampling; frame completion updates data and flags together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state  <= S_IDLE;
            r_rx_shift  <= '0;
            r_rx_tcnt   <= '0;
            r_rx_bcnt   <= '0;
            r_rx_perr   <= 1'b0;
            r_rx_data   <= '0;
            r_int_flag  <= 1'b0;
            r_perr_flag <= 1'b0;
            r_ferr_flag <= 1'b0;
            r_ovr_flag  <= 1'b0;
        end else begin
            // A completing frame below overrides this clear
            if (clearInterrupt) begin
                r_int_flag <= 1'b0;
                r_ovr_flag <= 1'b0;
            end
            case (r_rx_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_tcnt  <= '0;
                        r_rx_bcnt  <= '0;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == RTW'(OVERSAMPLE / 2 - 1)) begin
                            r_rx_tcnt  <= '0;
                            // Line back high at mid-start: glitch, not a frame
                            r_rx_state <= r_rx_sync2 ? S_IDLE : S_DATA;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + RTW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == RTW'(OVERSAMPLE - 1)) begin
                            r_rx_tcnt  <= '0;
                            r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_WIDTH-1:1]};
                            if (r_rx_bcnt == BCW'(DATA_WIDTH - 1)) begin
                                r_rx_state <= PAR_EN ? S_PARITY : S_STOP;
                            end else begin
                                r_rx_bcnt <= r_rx_bcnt + BCW'(1);
                            end
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + RTW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == RTW'(OVERSAMPLE - 1)) begin
                            r_rx_tcnt  <= '0;
                            r_rx_perr  <= r_rx_sync2 ^ (^r_rx_shift) ^ ODD_BIT;
                            r_rx_state <= S_STOP;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + RTW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == RTW'(OVERSAMPLE - 1)) begin
                            r_rx_tcnt   <= '0;
                            r_rx_state  <= S_IDLE;
                            r_rx_data   <= r_rx_shift;
                            r_ferr_flag <= ~r_rx_sync2;
                            r_perr_flag <= PAR_EN ? r_rx_perr : 1'b0;
                            r_int_flag  <= 1'b1;
                            if (r_int_flag && !clearInterrupt) begin
                                r_ovr_flag <= 1'b1;
                            end else begin
                                r_ovr_flag <= r_ovr_flag;
                            end
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + RTW'(1);
                        end
                    end
                end
                default: begin
                    r_rx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ReceivedData    = r_rx_data;
    assign RXInterrputFlag = r_int_flag;
    assign PARITYERRORFlag = r_perr_flag;
    assign FRAMEERRORFlag  = r_ferr_flag;
    assign OVERRUNFlag     = r_ovr_flag;

endmodule

// File: tb/tb_uart_duplex_core.sv
// Directed testbench for uart_duplex_core at DIV=1 (16 cycles per bit).
// DW may be overridden (8 or 9); parity checks follow UART_PARITY_EN.
module tb_uart_duplex_core #(
    parameter int DW = 8
);
    localparam int OS   = 16;
`ifdef UART_PARITY_EN
    localparam int P    = 1;
`else
    localparam int P    = 0;
`endif
    localparam int NB   = 1 + DW + P + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          trans = 1'b0;
    logic          clr = 1'b0;
    logic          rx_drv = 1'b1;
    logic          loop_en = 1'b0;
    logic          rx_line;
    logic          tx;
    logic          tx_busy;
    logic [DW-1:0] rx_data;
    logic          int_flag, perr_flag, ferr_flag, ovr_flag;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_duplex_core #(
        .CLK_FREQ(50000000), .BAUD_RATE(3125000), .OVERSAMPLE(OS),
        .DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .Data(data_in), .Trans(trans), .RX(rx_line),
        .clearInterrupt(clr), .TX(tx), .TXBusy(tx_busy), .ReceivedData(rx_data),
        .RXInterrputFlag(int_flag), .PARITYERRORFlag(perr_flag),
        .FRAMEERRORFlag(ferr_flag), .OVERRUNFlag(ovr_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Drive one frame on RX at 16 cycles/bit; optionally raise clearInterrupt
    // exactly in the cycle where the DUT samples the stop bit.
    task automatic send_rx(input logic [DW-1:0] d, input logic flip, input logic stopv,
                           input logic clr_done);
        $display("rx frame: data=%0h flip=%0b stop=%0b clr_at_done=%0b", d, flip, stopv, clr_done);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_drv = d[i];
            repeat (OS) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ flip;
        repeat (OS) @(negedge clk);
`endif
        rx_drv = stopv;
        if (clr_done) begin
            repeat (2 + OS / 2) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (OS - 3 - OS / 2) @(negedge clk);
        end else begin
            repeat (OS) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * OS) @(negedge clk);
    endtask

    function automatic logic exp_tx_bit(input logic [DW-1:0] d, input int f);
        if (f == 0) return 1'b0;
        if (f <= DW) return d[f-1];
        if (P == 1 && f == DW + 1) return ^d;
        return 1'b1;
    endfunction

    typedef struct packed {
        logic [8:0] data;
        logic       flip;
        logic       stopv;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } rx_vec_t;

    rx_vec_t vecs [6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] tmp9;
        int         n;

        vecs[0] = '{9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
        vecs[1] = '{9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0};
        vecs[2] = '{9'h096, 1'b0, 1'b1, 9'h096, 1'b0, 1'b0};
        vecs[3] = '{9'h03C, 1'b0, 1'b0, 9'h03C, 1'b1, 1'b0};
        vecs[4] = '{9'h05A, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b1};
        vecs[5] = '{9'h1A5, 1'b0, 1'b1, 9'h1A5, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_int", 32'(int_flag), 32'd0);
        check("reset_perr", 32'(perr_flag), 32'd0);
        check("reset_ferr", 32'(ferr_flag), 32'd0);
        check("reset_ovr", 32'(ovr_flag), 32'd0);

        // TX waveform of 0xA5, sampled mid-bit
        tmp9 = 9'h0A5;
        @(negedge clk); data_in = tmp9[DW-1:0]; trans = 1'b1;
        @(negedge clk); trans = 1'b0;
        $display("tx frame: data=%0h", data_in);
        check("tx_busy_start", 32'(tx_busy), 32'd1);
        repeat (OS / 2) @(negedge clk);
        for (int f = 0; f < NB; f++) begin
            check($sformatf("tx_bit%0d", f), 32'(tx), 32'(exp_tx_bit(data_in, f)));
            if (f < NB - 1) repeat (OS) @(negedge clk);
        end
        repeat (OS / 2 - 1) @(negedge clk);
        check("tx_busy_last", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("tx_busy_end", 32'(tx_busy), 32'd0);
        check("tx_idle", 32'(tx), 32'd1);

        // Loopback 0x3C
        tmp9 = 9'h03C;
        loop_en = 1'b1;
        @(negedge clk); data_in = tmp9[DW-1:0]; trans = 1'b1;
        @(negedge clk); trans = 1'b0;
        $display("loopback frame: data=%0h", data_in);
        n = 0;
        while (!int_flag && n < 4 * NB * OS) begin @(negedge clk); n++; end
        check("loop_int", 32'(int_flag), 32'd1);
        check("loop_data", 32'(rx_data), 32'(tmp9[DW-1:0]));
        check("loop_ferr", 32'(ferr_flag), 32'd0);
        check("loop_perr", 32'(perr_flag), 32'd0);
        check("loop_ovr", 32'(ovr_flag), 32'd0);
        n = 0;
        while (tx_busy && n < 4 * NB * OS) begin @(negedge clk); n++; end
        check("loop_busy_done", 32'(tx_busy), 32'd0);
        loop_en = 1'b0;
        pulse_clear();
        check("loop_clear_int", 32'(int_flag), 32'd0);

        // Glitch: 5 low cycles must be rejected
        $display("rx glitch: 5 cycles low");
        @(negedge clk); rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * OS) @(negedge clk);
        check("glitch_int", 32'(int_flag), 32'd0);
        check("glitch_ferr", 32'(ferr_flag), 32'd0);
        check("glitch_data", 32'(rx_data), 32'(tmp9[DW-1:0]));

        // Table-driven RX frames
        for (int i = 0; i < 6; i++) begin
            pulse_clear();
            send_rx(vecs[i].data[DW-1:0], vecs[i].flip, vecs[i].stopv, 1'b0);
            check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data[DW-1:0]));
            check($sformatf("vec%0d_int", i), 32'(int_flag), 32'd1);
            check($sformatf("vec%0d_ferr", i), 32'(ferr_flag), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_perr", i), 32'(perr_flag), (P == 1) ? 32'(vecs[i].exp_perr) : 32'd0);
            check($sformatf("vec%0d_ovr", i), 32'(ovr_flag), 32'd0);
        end

        // Overrun: two frames without clear
        pulse_clear();
        send_rx(DW'(8'h11), 1'b0, 1'b1, 1'b0);
        send_rx(DW'(8'h22), 1'b0, 1'b1, 1'b0);
        check("ovr_data", 32'(rx_data), 32'h22);
        check("ovr_flag", 32'(ovr_flag), 32'd1);
        check("ovr_int", 32'(int_flag), 32'd1);

        // Clear coinciding with completion while overrun already set: overrun held
        send_rx(DW'(8'h33), 1'b0, 1'b1, 1'b1);
        check("ovr_hold_data", 32'(rx_data), 32'h33);
        check("ovr_hold_int", 32'(int_flag), 32'd1);
        check("ovr_hold_flag", 32'(ovr_flag), 32'd1);

        // Clear coinciding with completion of frame 2: no overrun
        pulse_clear();
        check("clr_int", 32'(int_flag), 32'd0);
        check("clr_ovr", 32'(ovr_flag), 32'd0);
        send_rx(DW'(8'h11), 1'b0, 1'b1, 1'b0);
        send_rx(DW'(8'h22), 1'b0, 1'b1, 1'b1);
        check("race_data", 32'(rx_data), 32'h22);
        check("race_int", 32'(int_flag), 32'd1);
        check("race_ovr", 32'(ovr_flag), 32'd0);

        // Reset asserted mid-TX (data bit 3) and mid-RX, between clock edges
        tmp9 = 9'h0F0;
        @(negedge clk); data_in = tmp9[DW-1:0]; trans = 1'b1; rx_drv = 1'b0;
        @(negedge clk); trans = 1'b0;
        $display("tx+rx interrupted by reset: data=%0h", data_in);
        repeat (4 * OS + OS / 2) @(negedge clk);
        check("pre_reset_tx_bit3", 32'(tx), 32'd0);
        #2;
        reset = 1'b1;
        rx_drv = 1'b1;
        #1;
        check("mid_reset_tx", 32'(tx), 32'd1);
        check("mid_reset_busy", 32'(tx_busy), 32'd0);
        check("mid_reset_int", 32'(int_flag), 32'd0);
        check("mid_reset_ovr", 32'(ovr_flag), 32'd0);
        check("mid_reset_ferr", 32'(ferr_flag), 32'd0);
        check("mid_reset_perr", 32'(perr_flag), 32'd0);
        check("mid_reset_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (NB * OS + 40) @(negedge clk);
        check("post_reset_int", 32'(int_flag), 32'd0);
        check("post_reset_ferr", 32'(ferr_flag), 32'd0);
        check("post_reset_tx", 32'(tx), 32'd1);
        send_rx(DW'(8'hC3), 1'b0, 1'b1, 1'b0);
        check("post_reset_data", 32'(rx_data), 32'hC3);
        check("post_reset_int2", 32'(int_flag), 32'd1);
        check("post_reset_ferr2", 32'(ferr_flag), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
